// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and widths for the count monitor.
// Holds the monitor state enum and the error/wrap counter widths.
package count_monitor_pkg;

    localparam int ERR_W  = 8;
    localparam int WRAP_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear and optional saturation.
// Ports: clock, reset (sync, active-low), clear, increment, value.
module sat_counter #(
    parameter int Width    = 8,
    parameter bit Saturate = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [Width-1:0] value
);

    logic at_max;

    assign at_max = &value;

    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (increment && !(Saturate && at_max)) begin
            value <= value + Width'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: watches a free-running up-counter, locks onto its sequence,
// reports skips and faults after too many skips since the last lock.
// Ports: clock, reset (sync, active-low), count, enable, clear_fault,
//        locked, mismatch, fault, error_count, wrap_count.
// Option: COUNT_MONITOR_WRAP_STATS_EN enables the wrap_count register;
//         otherwise wrap_count is tied to zero.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int Size      = 5,
    parameter int MaxErrors = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [Size-1:0]   count,
    input  logic              enable,
    input  logic              clear_fault,
    output logic              locked,
    output logic              mismatch,
    output logic              fault,
    output logic [ERR_W-1:0]  error_count,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [ERR_W-1:0] LIMIT_M1 = ERR_W'(MaxErrors - 1);

    state_t            state;
    state_t            next_state;
    logic [Size-1:0]   expected;
    logic              primed;
    logic [ERR_W-1:0]  since_lock;
    logic              in_seq;
    logic              sampling;
    logic              miss;
    logic              since_clr;
    logic              limit_hit;

    assign in_seq    = (count == expected);
    // the current miss is the one that brings the since-lock tally to MaxErrors
    assign limit_hit = (since_lock >= LIMIT_M1);

    always_comb begin
        next_state = state;
        sampling   = 1'b0;
        miss       = 1'b0;
        since_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    next_state = SYNC;
                    since_clr  = 1'b1;
                end
            end
            SYNC: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    sampling = 1'b1;
                    // primed: a SYNC sample was already taken last cycle
                    if (primed && in_seq) begin
                        next_state = TRACK;
                    end
                end
            end
            TRACK: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    sampling = 1'b1;
                    if (!in_seq) begin
                        miss = 1'b1;
                        if (limit_hit) begin
                            next_state = FAULT;
                        end
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    if (enable) begin
                        next_state = SYNC;
                        since_clr  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            primed   <= 1'b0;
            expected <= '0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state    <= next_state;
            primed   <= (state == SYNC);
            if (sampling) begin
                // reload from the sample so a single skip costs one miss
                expected <= count + Size'(1);
            end
            locked   <= (next_state == TRACK);
            fault    <= (next_state == FAULT);
            mismatch <= miss;
        end
    end

    sat_counter #(
        .Width    (ERR_W),
        .Saturate (1'b1)
    ) u_err_ctr (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .increment (miss),
        .value     (error_count)
    );

    sat_counter #(
        .Width    (ERR_W),
        .Saturate (1'b1)
    ) u_since_ctr (
        .clock     (clock),
        .reset     (reset),
        .clear     (since_clr),
        .increment (miss),
        .value     (since_lock)
    );

`ifdef COUNT_MONITOR_WRAP_STATS_EN
    logic wrap_hit;

    assign wrap_hit = (state == TRACK) && enable && in_seq
                      && (count == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrap_count <= '0;
        end else if (wrap_hit) begin
            wrap_count <= wrap_count + WRAP_W'(1);
        end
    end
`else
    assign wrap_count = '0;
`endif

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter Size, default 5, width of the observed count bus.
REQ-002 SHALL have parameter MaxErrors, default 3, mismatches since lock that force FAULT; legal range 1..255.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port count  input  Size  value driven by the free-running up-counter under observation.
REQ-006 SHALL have port enable  input  1  monitoring enable.
REQ-007 SHALL have port clear_fault  input  1  releases FAULT state.
REQ-008 SHALL have port locked  output  1  high while in TRACK.
REQ-009 SHALL have port mismatch  output  1  one-cycle pulse per detected mismatch.
REQ-010 SHALL have port fault  output  1  high while in FAULT.
REQ-011 SHALL have port error_count  output  8  total mismatches, saturating at 255.
REQ-012 SHALL have port wrap_count  output  16  observed counter wrap-arounds, modulo 2^16.

Function
REQ-013 SHALL implement FSM states IDLE, SYNC, TRACK, FAULT; all outputs registered.
REQ-014 IDLE: enable=1 -> SYNC next cycle; otherwise stay.
REQ-015 SYNC: each cycle sample count, set expected = (count+1) mod 2^Size; if sample equals prior expected (second consecutive in-sequence sample) -> TRACK.
REQ-016 TRACK: each cycle compare count with expected; expected always reloads (count+1) mod 2^Size, so one skip yields one mismatch.
REQ-017 Mismatch in TRACK SHALL pulse mismatch in the following cycle and increment error_count (saturate at 255) and the since-lock error counter.
REQ-018 When since-lock error counter reaches MaxErrors, SHALL enter FAULT in the same cycle mismatch pulses; since-lock counter clears on each entry to SYNC.
REQ-019 Matching sample equal to 0 in TRACK SHALL increment wrap_count by 1 (wraps 65535->0).
REQ-020 FAULT: no comparison, mismatch=0, locked=0, fault=1; sticky regardless of enable.
REQ-021 FAULT with clear_fault=1: -> SYNC if enable=1, else IDLE.
REQ-022 enable=0 in SYNC or TRACK SHALL return to IDLE next cycle; error_count and wrap_count retained.
REQ-023 locked SHALL rise the cycle after the TRACK transition and fall the cycle after leaving TRACK.

Reset
REQ-024 reset=0 at posedge SHALL force IDLE, locked=0, mismatch=0, fault=0, error_count=0, wrap_count=0, expected=0, mid-operation included; reset dominates enable and clear_fault.

Configuration
REQ-025 With COUNT_MONITOR_WRAP_STATS_EN defined, wrap_count SHALL behave per REQ-019.
REQ-026 Without COUNT_MONITOR_WRAP_STATS_EN, wrap_count SHALL be constant 0 and no wrap register SHALL be synthesized; port list unchanged.

Structure
REQ-027 Package count_monitor_pkg SHALL hold the state enum, ERR_W=8, WRAP_W=16 constants.
REQ-028 Sub-module sat_counter (parameterized width, increment, clear, saturate flag) SHALL implement error_count and the since-lock counter.

Verification
REQ-029 Reset: reset=0 for 2 cycles during TRACK -> all outputs 0, state IDLE next cycle.
REQ-030 Lock: enable=1, count 0,1,2,3 -> locked=1 after third sample; no mismatch.
REQ-031 Glitch: TRACK, count 7,8,12,13 -> single mismatch pulse after 12, error_count=1, locked stays 1.
REQ-032 Fault: three skips in TRACK (MaxErrors=3) -> fault=1, locked=0; clear_fault=1 with enable=1 -> SYNC, relock after two in-sequence samples.
REQ-033 Wrap: Size=5, count 30,31,0,1 in TRACK -> wrap_count=1 with macro, 0 without.
REQ-034 Saturation: force 300 mismatches (MaxErrors=255, re-clear faults) -> error_count holds 255.
